// File: rtl/segled_scan.sv
// segled_scan: time-multiplexed hex 7-segment display driver.
//
// Scans DIGITS hex digits taken from one packed data word onto a
// common-digit LED display. Each digit owns a slot of PRESCALE clock
// cycles. The first BLANK_CYCLES cycles of every slot are dark so that
// the previous digit's enable cannot ghost onto the next one. Input data
// lands in a shadow register on load. It moves to the active register
// only at the frame boundary, so a frame never shows a mix of old and
// new values.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   data        packed nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_in       per-digit decimal point request
//   blank_mask  per-digit force-dark
//   lzb_en      leading-zero blanking enable
//   load        capture data/dp_in/blank_mask/lzb_en into the shadow register
//   segs        segments {g,f,e,d,c,b,a}
//   dp          decimal point segment
//   digit_en    one-hot (or zero) digit select
//   frame_tick  one-cycle pulse presented with the first cycle of each frame
module segled_scan #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lzb_en,
    input  logic                  load,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Inactive output levels; XOR with these applies the pin polarity.
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic [4*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_blank;
    logic                r_sh_lzb;

    logic [4*DIGITS-1:0] r_ac_data;
    logic [DIGITS-1:0]   r_ac_dp;
    logic [DIGITS-1:0]   r_ac_blank;
    logic                r_ac_lzb;

    logic [6:0]          r_segs;
    logic                r_dp;
    logic [DIGITS-1:0]   r_digit_en;
    logic                r_frame_tick;

    logic                w_cnt_wrap;
    logic                w_frame_end;
    logic                w_past_blank;
    logic [DIGITS-1:0]   w_lzb;
    logic [3:0]          w_nib;
    logic                w_blank_cur;
    logic                w_lzb_cur;
    logic                w_dp_cur;
    logic                w_vis;
    logic [DIGITS-1:0]   w_den;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_cnt_wrap && (r_idx == IDX_LAST);

    // With no blank window every cycle of the slot is visible; the
    // comparison is only generated when it can be false.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_past_blank = 1'b1;
        end else begin : g_blank
            assign w_past_blank = (r_cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Prescaler and slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow register: last load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_lzb   <= 1'b0;
        end else if (load) begin
            r_sh_data  <= data;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank_mask;
            r_sh_lzb   <= lzb_en;
        end
    end

    // Active register copies the pre-edge shadow at the frame boundary,
    // so a load on the boundary cycle itself waits one more frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac_data  <= '0;
            r_ac_dp    <= '0;
            r_ac_blank <= '0;
            r_ac_lzb   <= 1'b0;
        end else if (w_frame_end) begin
            r_ac_data  <= r_sh_data;
            r_ac_dp    <= r_sh_dp;
            r_ac_blank <= r_sh_blank;
            r_ac_lzb   <= r_sh_lzb;
        end
    end

    // Leading-zero blanking: walk from the top digit down, keeping a
    // running "everything above and including me is zero" flag.
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        w_lzb      = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            v_zero_run = v_zero_run && (r_ac_data[4*(DIGITS-1-k) +: 4] == 4'h0);
            w_lzb[DIGITS-1-k] = r_ac_lzb && (k != DIGITS - 1) && v_zero_run;
        end
    end

    // Per-slot attribute select.
    always_comb begin
        w_nib       = '0;
        w_blank_cur = 1'b0;
        w_lzb_cur   = 1'b0;
        w_dp_cur    = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_ac_data[4*k +: 4];
                w_blank_cur = r_ac_blank[k];
                w_lzb_cur   = w_lzb[k];
                w_dp_cur    = r_ac_dp[k];
            end
        end
    end

    assign w_vis = !w_blank_cur && !w_lzb_cur && w_past_blank;

    always_comb begin
        w_den = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_den[k] = w_vis && (r_idx == IDX_W'(k));
        end
    end

    // Registered outputs, one cycle behind (idx, cnt).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs       <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_digit_en   <= DIG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_segs       <= (w_vis ? hex7(w_nib) : 7'h00) ^ SEG_OFF;
            r_dp         <= (w_vis && w_dp_cur) ^ DP_OFF;
            r_digit_en   <= w_den ^ DIG_OFF;
            r_frame_tick <= (r_cnt == '0) && (r_idx == '0);
        end
    end

    assign segs       = r_segs;
    assign dp         = r_dp;
    assign digit_en   = r_digit_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_segled_scan.sv
module tb_segled_scan;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int BL = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lzb_en = 1'b0;
    logic        load = 1'b0;

    logic [6:0]  segA, segB;
    logic        dpA, dpB;
    logic [3:0]  denA, denB;
    logic        ftA, ftB;

    int n_tests = 0;
    int n_fail  = 0;
    logic sb_en = 1'b0;

    segled_scan #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(BL),
                  .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in),
        .blank_mask(blank_mask), .lzb_en(lzb_en), .load(load),
        .segs(segA), .dp(dpA), .digit_en(denA), .frame_tick(ftA));

    segled_scan #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(BL),
                  .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in),
        .blank_mask(blank_mask), .lzb_en(lzb_en), .load(load),
        .segs(segB), .dp(dpB), .digit_en(denB), .frame_tick(ftB));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan is derived from the number of
    // clock edges since reset; outputs are what the display should show
    // after the edge.
    logic [6:0]  seg_tbl [16];
    int          m_n = 0;
    logic [15:0] sh_data = '0, ac_data = '0;
    logic [3:0]  sh_dp = '0, ac_dp = '0, sh_blank = '0, ac_blank = '0;
    logic        sh_lzb = 1'b0, ac_lzb = 1'b0;
    logic [3:0]  exp_den = '0;
    logic [6:0]  exp_segs = '0;
    logic        exp_dp = 1'b0, exp_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0;
            sh_data = '0; sh_dp = '0; sh_blank = '0; sh_lzb = 1'b0;
            ac_data = '0; ac_dp = '0; ac_blank = '0; ac_lzb = 1'b0;
            exp_den = '0; exp_segs = '0; exp_dp = 1'b0; exp_tick = 1'b0;
        end else begin
            int cnt, idx;
            logic lz, vis;
            logic [15:0] above;
            logic [3:0] nib;
            cnt   = m_n % P;
            idx   = (m_n / P) % D;
            above = ac_data >> (4 * idx);
            nib   = above[3:0];
            lz    = ac_lzb && (idx > 0) && (above == 16'h0);
            vis   = !ac_blank[idx] && !lz && (cnt >= BL);
            exp_den  = vis ? 4'(1 << idx) : 4'h0;
            exp_segs = vis ? seg_tbl[nib] : 7'h00;
            exp_dp   = vis && ac_dp[idx];
            exp_tick = ((m_n % (P * D)) == 0);
            if ((m_n % (P * D)) == P * D - 1) begin
                ac_data = sh_data; ac_dp = sh_dp; ac_blank = sh_blank; ac_lzb = sh_lzb;
            end
            if (load) begin
                sh_data = data; sh_dp = dp_in; sh_blank = blank_mask; sh_lzb = lzb_en;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            chk("sb_den_a",  {28'h0, denA}, {28'h0, exp_den});
            chk("sb_seg_a",  {25'h0, segA}, {25'h0, exp_segs});
            chk("sb_dp_a",   {31'h0, dpA},  {31'h0, exp_dp});
            chk("sb_tick_a", {31'h0, ftA},  {31'h0, exp_tick});
            chk("sb_den_b",  {28'h0, denB}, {28'h0, 4'(~exp_den)});
            chk("sb_seg_b",  {25'h0, segB}, {25'h0, 7'(~exp_segs)});
            chk("sb_dp_b",   {31'h0, dpB},  {31'h0, !exp_dp});
            chk("sb_tick_b", {31'h0, ftB},  {31'h0, exp_tick});
        end
    end

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpi;
        logic [3:0]      blank;
        logic            lzb;
        logic [3:0][3:0] den_e;
        logic [3:0][6:0] seg_e;
        logic [3:0]      dp_e;
    } vec_t;

    vec_t tbl [9];

    task automatic wait_tick();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ftA && cyc < 40);
        if (!ftA) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got no frame_tick within %0d cycles, required one", cyc);
        end
    endtask

    // Called on the negedge where frame_tick is presented; samples each
    // digit in the middle of its visible window.
    task automatic sample_frame(input int v);
        for (int d = 0; d < D; d++) begin
            repeat ((d == 0) ? 2 : 4) @(negedge clk);
            chk($sformatf("v%0d_d%0d_den_a", v, d), {28'h0, denA}, {28'h0, tbl[v].den_e[d]});
            chk($sformatf("v%0d_d%0d_seg_a", v, d), {25'h0, segA}, {25'h0, tbl[v].seg_e[d]});
            chk($sformatf("v%0d_d%0d_dp_a",  v, d), {31'h0, dpA},  {31'h0, tbl[v].dp_e[d]});
            chk($sformatf("v%0d_d%0d_den_b", v, d), {28'h0, denB}, {28'h0, 4'(~tbl[v].den_e[d])});
            chk($sformatf("v%0d_d%0d_seg_b", v, d), {25'h0, segB}, {25'h0, 7'(~tbl[v].seg_e[d])});
            chk($sformatf("v%0d_d%0d_dp_b",  v, d), {31'h0, dpB},  {31'h0, !tbl[v].dp_e[d]});
        end
    endtask

    task automatic apply_vec(input int v);
        wait_tick();
        data = tbl[v].data; dp_in = tbl[v].dpi; blank_mask = tbl[v].blank;
        lzb_en = tbl[v].lzb; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_tick();
        sample_frame(v);
    endtask

    initial begin
        int gap;
        logic [15:0] masks [4];

        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        masks = '{16'hFFFF, 16'h00FF, 16'h0F0F, 16'h000F};

        tbl[0] = '{16'h1A2F, 4'b0100, 4'b0000, 1'b0,
                   {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'h06, 7'h77, 7'h5B, 7'h71}, 4'b0100};
        tbl[1] = '{16'h0030, 4'b0000, 4'b0000, 1'b1,
                   {4'b0000, 4'b0000, 4'b0010, 4'b0001},
                   {7'h00, 7'h00, 7'h4F, 7'h3F}, 4'b0000};
        tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                   {4'b0000, 4'b0000, 4'b0000, 4'b0001},
                   {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
        tbl[3] = '{16'h8888, 4'b1111, 4'b0010, 1'b0,
                   {4'b1000, 4'b0100, 4'b0000, 4'b0001},
                   {7'h7F, 7'h7F, 7'h00, 7'h7F}, 4'b1101};
        tbl[4] = '{16'hC5E9, 4'b1000, 4'b0000, 1'b1,
                   {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'h39, 7'h6D, 7'h79, 7'h6F}, 4'b1000};
        tbl[5] = '{16'h0D07, 4'b1111, 4'b0001, 1'b1,
                   {4'b0000, 4'b0100, 4'b0010, 4'b0000},
                   {7'h00, 7'h5E, 7'h3F, 7'h00}, 4'b0110};
        tbl[6] = '{16'h7777, 4'b0000, 4'b0000, 1'b0,
                   {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'h07, 7'h07, 7'h07, 7'h07}, 4'b0000};
        tbl[7] = '{16'h2222, 4'b0000, 4'b0000, 1'b0,
                   {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000};
        tbl[8] = '{16'h4444, 4'b0000, 4'b0000, 1'b0,
                   {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'h66, 7'h66, 7'h66, 7'h66}, 4'b0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_den_a", {28'h0, denA}, 32'h0);
        chk("rst_seg_a", {25'h0, segA}, 32'h0);
        chk("rst_dp_a",  {31'h0, dpA},  32'h0);
        chk("rst_tick",  {31'h0, ftA},  32'h0);
        chk("rst_den_b", {28'h0, denB}, 32'hF);
        chk("rst_seg_b", {25'h0, segB}, 32'h7F);
        chk("rst_dp_b",  {31'h0, dpB},  32'h1);
        sb_en = 1'b1;

        // First slots after release: blank cycle, then digit 0 for three cycles
        rst_n = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            logic [3:0] e_den;
            e_den = (p >= 2 && p <= 4) ? 4'b0001 : (p == 6) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            chk($sformatf("boot_p%0d_den", p),  {28'h0, denA}, {28'h0, e_den});
            chk($sformatf("boot_p%0d_seg", p),  {25'h0, segA}, (e_den != 0) ? 32'h3F : 32'h0);
            chk($sformatf("boot_p%0d_tick", p), {31'h0, ftA},  (p == 1) ? 32'h1 : 32'h0);
        end

        // Frame tick period
        wait_tick();
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!ftA && gap < 40);
        chk("tick_period", gap, P * D);

        // Table-driven decode, lzb, blank and polarity vectors
        for (int v = 0; v < 7; v++) apply_vec(v);

        // Frame coherence: two loads mid-frame, only the last one shows next frame
        wait_tick();
        repeat (5) @(negedge clk);
        data = 16'h1111; dp_in = '0; blank_mask = '0; lzb_en = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        data = 16'h2222; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (2) @(negedge clk);
        chk("coh_cur_seg", {25'h0, segA}, 32'h07);
        wait_tick();
        sample_frame(7);

        // Load presented on the frame-boundary cycle is deferred one frame
        data = 16'h4444; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_tick();
        sample_frame(7);
        wait_tick();
        sample_frame(8);

        // Asynchronous reset mid-scan at idx=2, cnt=3
        wait_tick();
        repeat (11) @(negedge clk);
        chk("pre_rst_seg", {25'h0, segA}, 32'h66);
        #1 rst_n = 1'b0;
        #1;
        chk("async_den_a", {28'h0, denA}, 32'h0);
        chk("async_seg_a", {25'h0, segA}, 32'h0);
        chk("async_den_b", {28'h0, denB}, 32'hF);
        chk("async_seg_b", {25'h0, segB}, 32'h7F);
        chk("async_dp_b",  {31'h0, dpB},  32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rerun_den", {28'h0, denA}, 32'h1);
        chk("rerun_seg", {25'h0, segA}, 32'h3F);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            load       = ($urandom_range(0, 7) == 0);
            data       = 16'($urandom) & masks[$urandom_range(0, 3)];
            dp_in      = 4'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lzb_en     = 1'($urandom);
        end
        load = 1'b0;
        repeat (20) @(negedge clk);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segled_scan.md
Name: segled_scan

Overview:
- Parametrised successor to the single-nibble hex 7-segment decoder.
- Drives a time-multiplexed, common-digit display of DIGITS hex digits from one packed data word.
- Adds the following on top of the hex decode table:
  - a refresh prescaler;
  - per-digit decimal points and blanking;
  - leading-zero blanking;
  - inter-digit ghost guard;
  - frame-coherent data update;
  - selectable output polarity.
- Sits between a CPU-visible register (or counter) and the board LED pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 1000, clk cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2, cycles at start of each slot with all digits off (0 allowed)
SEG_ACTIVE_LOW, 0, 1 = segs/dp pins active-low
DIG_ACTIVE_LOW, 0, 1 = digit_en pins active-low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data  in  4*DIGITS  packed nibbles; digit i = data[4i+3:4i], digit 0 rightmost
dp_in  in  DIGITS  decimal point request per digit
blank_mask  in  DIGITS  1 = force digit dark
lzb_en  in  1  enable leading-zero blanking
load  in  1  capture data/dp_in/blank_mask/lzb_en into shadow register
segs  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp  out  1  decimal point segment
digit_en  out  DIGITS  one-hot (or zero) digit select
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async, rst_n=0):
  - prescaler cnt=0, slot index idx=0;
  - shadow and active registers =0;
  - frame_tick=0;
  - segs, dp and digit_en driven to their inactive levels: all 0 with polarity 0, all 1 with polarity 1.
  - On release, scanning starts at idx=0, cnt=0.
- Shadow register:
  - On any cycle with load=1, shadow <= inputs.
  - The last load wins; no handshake.
- Active register:
  - active <= shadow on the cycle cnt==PRESCALE-1 && idx==DIGITS-1 (frame boundary), so it is in effect for digit 0 of the next frame.
  - A load on that same cycle is not included; it takes effect one frame later.
- Prescaler:
  - cnt counts 0..PRESCALE-1, then wraps to 0.
  - On wrap, idx increments, wrapping DIGITS-1 -> 0.
- frame_tick is registered: high for exactly the one cycle during which idx==0 && cnt==0 is presented.
- Leading-zero blanking (lzb), per digit i:
  - lzb(i) = lzb_en && i>0 && all active nibbles i..DIGITS-1 are 0.
  - Digit 0 is never lz-blanked.
  - dp_in does not inhibit lzb.
- Digit visibility: vis = !blank_mask[idx] && !lzb(idx) && cnt >= BLANK_CYCLES.
- Output register, updated every cycle from the current (idx, cnt, active); one cycle latency:
  - digit_en = vis ? (1<<idx) : 0, then XOR'd with all-ones if DIG_ACTIVE_LOW.
  - segs = hex decode of active nibble idx, using the standard table:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - segs forced to 0 when !vis.
  - dp = dp_in(active)[idx] && vis.
  - segs and dp inverted if SEG_ACTIVE_LOW.
- At most one digit_en bit is ever active; no two digits are active in adjacent cycles unless BLANK_CYCLES=0.
- DIGITS=1:
  - idx is constant 0;
  - every slot is a frame, and frame_tick pulses every PRESCALE cycles.
- All data nibbles are 4-bit; there is no carry or arithmetic beyond cnt and idx. cnt width is clog2(PRESCALE), idx width is clog2(DIGITS) (minimum 1).

Test Plan:
- Reset/idle:
  - Setup: DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, polarities 0.
  - Stimulus: hold rst_n=0, then release; data=0, no load.
  - Required: during reset digit_en=0000, segs=00, dp=0. After release, digit 0 shows segs=3F with digit_en=0001 for cycles 2..4 of the slot (one blank cycle plus one cycle latency), then digit 1.
- Scan and decode:
  - Stimulus: load data=16'h1A2F, dp_in=0100, lzb_en=0; wait one frame.
  - Required: successive slots give (digit_en, segs) = (0001, 71), (0010, 5B), (0100, 77) with dp=1, (1000, 06).
  - Required: frame_tick pulses once per 16 cycles.
- Frame coherence:
  - Stimulus: load 16'h1111 mid-frame, then 16'h2222 two cycles later.
  - Required: the current frame is unchanged; the next frame shows only 5B on all digits; 06 never appears.
  - Stimulus: load on the boundary cycle.
  - Required: the new value is deferred one extra frame.
- Leading-zero blanking:
  - Stimulus: data=16'h0030, lzb_en=1.
  - Required: digits 3 and 2 have digit_en=0 and segs=00; digit 1 shows 4F; digit 0 shows 3F.
  - Stimulus: data=0000.
  - Required: only digit 0 is lit, showing 3F.
- Blank mask and polarity:
  - Setup: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1.
  - Stimulus: blank_mask=0010, data=16'h8888.
  - Required: digit 1 slot keeps digit_en=1111 and segs=7F with dp=1 (all inactive); other slots assert one low enable bit with segs=00.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 asynchronously while idx=2, cnt=3.
  - Required: outputs go to inactive levels in the same cycle without waiting for a clock edge; after release, the scan restarts at digit 0 with cleared data showing 3F.
